// File: rtl/vga_scan_timing.sv
`timescale 1ns/1ps
// Purpose: VGA scan timing generator + registered pixel/sync output stage for the chaos-map display path.
// Latency: pins show the coordinate that was on row/col one pixel period earlier (colour, HS, VS all aligned).
// Backpressure: none; free-running scan. The colour inputs must settle combinationally from row/col.
//
// Ports:
//   CLK, RST                    - system clock, synchronous active-high reset
//   red_in/green_in/blue_in     - colour bits for the current row/col
//   row, col                    - vertical / horizontal scan counters (not masked in blanking)
//   active                      - current counters are inside the visible area
//   pix_en                      - one-CLK strobe per pixel period
//   frame_start, frame_cnt      - one-CLK pulse at each frame wrap, completed-frame counter
//   VGA_R/G/B, VGA_HS/VGA_VS    - registered connector pins
module vga_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        red_in,
  input  logic        green_in,
  input  logic        blue_in,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        active,
  output logic        pix_en,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits because ACTIVE+FP+SYNC may reach 1024.
  localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Deasserted pin level: high for active-low sync, low for active-high sync.
  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
    $error("vga_scan_timing: totals must be <= 1024 and CLK_DIV >= 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             line_end;
  logic             frame_end;

  assign row = vcnt;
  assign col = hcnt;

  always_comb begin
    div_nxt   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    active    = ({1'b0, hcnt} < H_VIS_END) && ({1'b0, vcnt} < V_VIS_END);
    hs_raw    = ({1'b0, hcnt} >= HS_BEG) && ({1'b0, hcnt} < HS_END);
    vs_raw    = ({1'b0, vcnt} >= VS_BEG) && ({1'b0, vcnt} < VS_END);
    line_end  = (hcnt == H_LAST);
    frame_end = line_end && (vcnt == V_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt     <= '0;
      pix_en      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      VGA_R       <= 1'b0;
      VGA_G       <= 1'b0;
      VGA_B       <= 1'b0;
      VGA_HS      <= SYNC_IDLE;
      VGA_VS      <= SYNC_IDLE;
    end else begin
      div_cnt     <= div_nxt;
      // Registered strobe: mirrors div_cnt == CLK_DIV-1 but reads 0 straight out of reset.
      pix_en      <= (div_nxt == DIV_LAST);
      frame_start <= 1'b0;
      if (pix_en) begin
        if (line_end) begin
          hcnt <= '0;
          if (frame_end) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            vcnt <= vcnt + 10'd1;
          end
        end else begin
          hcnt <= hcnt + 10'd1;
        end
        // Colour and sync are captured on the same edge so they share the one-pixel delay.
        VGA_R  <= red_in   & active;
        VGA_G  <= green_in & active;
        VGA_B  <= blue_in  & active;
        VGA_HS <= hs_raw ^ SYNC_IDLE;
        VGA_VS <= vs_raw ^ SYNC_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
`timescale 1ns/1ps
module tb_vga_scan_timing;

  // Reduced geometry keeps several complete frames within a short run.
  localparam int HA = 20, HFP = 3, HSY = 5, HBP = 4;
  localparam int VA = 10, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 32
  localparam int VT = VA + VFP + VSY + VBP;   // 17
  localparam int FRAME = HT * VT;             // pixels per frame
  localparam int NCYC = 7000;

  typedef struct packed {
    logic [9:0]  row;
    logic [9:0]  col;
    logic        act;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fcnt;
    logic        pe;
  } obs_t;

  logic        clk;
  logic        rst    [2];
  logic [2:0]  rgb_in [2];
  logic [9:0]  row_o  [2];
  logic [9:0]  col_o  [2];
  logic        act_o  [2];
  logic        pe_o   [2];
  logic        fs_o   [2];
  logic [15:0] fc_o   [2];
  logic        red_o  [2];
  logic        grn_o  [2];
  logic        blu_o  [2];
  logic        hs_o   [2];
  logic        vs_o   [2];
  obs_t        obs    [2];

  int checks = 0;
  int passes = 0;
  obs_t q0[$];
  obs_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CLK_DIV=2, active-low sync. Instance 1: CLK_DIV=1, active-high sync.
  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(2), .SYNC_POL(0)
  ) u_dut_a (
    .CLK(clk), .RST(rst[0]),
    .red_in(rgb_in[0][2]), .green_in(rgb_in[0][1]), .blue_in(rgb_in[0][0]),
    .row(row_o[0]), .col(col_o[0]), .active(act_o[0]), .pix_en(pe_o[0]),
    .frame_start(fs_o[0]), .frame_cnt(fc_o[0]),
    .VGA_R(red_o[0]), .VGA_G(grn_o[0]), .VGA_B(blu_o[0]),
    .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0])
  );

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(1), .SYNC_POL(1)
  ) u_dut_b (
    .CLK(clk), .RST(rst[1]),
    .red_in(rgb_in[1][2]), .green_in(rgb_in[1][1]), .blue_in(rgb_in[1][0]),
    .row(row_o[1]), .col(col_o[1]), .active(act_o[1]), .pix_en(pe_o[1]),
    .frame_start(fs_o[1]), .frame_cnt(fc_o[1]),
    .VGA_R(red_o[1]), .VGA_G(grn_o[1]), .VGA_B(blu_o[1]),
    .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1])
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_obs
    assign obs[gi] = {row_o[gi], col_o[gi], act_o[gi], red_o[gi], grn_o[gi], blu_o[gi],
                      hs_o[gi], vs_o[gi], fs_o[gi], fc_o[gi], pe_o[gi]};
  end

  function automatic int div_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int pol_of(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Pin level for a position inside/outside a sync window of the given polarity.
  function automatic logic sync_pin(int pos, int beg, int len, int pol);
    return logic'((pos >= beg && pos < beg + len) == (pol != 0));
  endfunction

  // State visible after an edge, given pixels completed (n) and CLKs since reset release (cyc).
  function automatic obs_t make_obs(int n, int cyc, logic fs, logic [4:0] pins, int div);
    obs_t o;
    int h, v;
    h      = n % HT;
    v      = (n / HT) % VT;
    o.row  = 10'(v);
    o.col  = 10'(h);
    o.act  = (h < HA) && (v < VA);
    o.rgb  = pins[4:2];
    o.hs   = pins[1];
    o.vs   = pins[0];
    o.fs   = fs;
    o.fcnt = 16'((n / FRAME) % 65536);
    o.pe   = (cyc >= 1) && ((cyc % div) == div - 1);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("row=%0d col=%0d act=%b rgb=%b hs=%b vs=%b fs=%b fcnt=%0d pe=%b",
                     o.row, o.col, o.act, o.rgb, o.hs, o.vs, o.fs, o.fcnt, o.pe);
  endfunction

  // Stimulus: random colour every CLK, reset at start and once mid-frame per instance.
  initial begin
    int   n   [2];
    int   cyc [2];
    int   rst_at [2];
    logic [4:0] pins [2];
    logic r, fs, pe_now, act, idle;
    int   h, v, div, pol;
    obs_t e;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rgb_in[d] = 3'b000; n[d] = 0; cyc[d] = 0; pins[d] = 5'b0;
    end
    // Instance 0: a CLK inside its third frame; instance 1: inside its third frame.
    rst_at[0] = 5 + 2 * (2 * FRAME) + $urandom_range(100, 2 * FRAME - 100);
    rst_at[1] = 5 + 2 * FRAME + $urandom_range(50, FRAME - 50);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        div = div_of(d);
        pol = pol_of(d);
        idle = (pol == 0);
        r = (c < 5) || (c == rst_at[d]);
        rst[d] = r;
        rgb_in[d] = 3'($urandom);
        fs = 1'b0;
        if (r) begin
          n[d] = 0; cyc[d] = 0;
          pins[d] = {3'b000, idle, idle};
        end else begin
          pe_now = (cyc[d] >= 1) && ((cyc[d] % div) == div - 1);
          if (pe_now) begin
            h = n[d] % HT;
            v = (n[d] / HT) % VT;
            act = (h < HA) && (v < VA);
            pins[d] = {rgb_in[d] & {3{act}},
                       sync_pin(h, HA + HFP, HSY, pol),
                       sync_pin(v, VA + VFP, VSY, pol)};
            n[d]++;
            fs = ((n[d] % FRAME) == 0);
          end
          cyc[d]++;
        end
        e = make_obs(n[d], cyc[d], fs, pins[d], div);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: after every edge, compare each instance's visible state with the oldest prediction.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if ((d == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          checks++;
          if (obs[d] !== e)
            $display("FAIL dut%0d scan_state @%0t: got %s | expected %s", d, $time, fmt(obs[d]), fmt(e));
          else
            passes++;
        end
      end
    end
  end

endmodule
